exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception and pipeline control unit for the 5-stage MIPS core.
- Resolves the MEM-stage raw exception flags and pending interrupts against the forwarded CP0 Status/Cause into one final exception type. That type feeds CP0 (EPC/Cause/EXL update).
- Generates pipeline flush, redirect PC and the 6-bit stall vector.
- A post-exception hold-off FSM guarantees exactly one exception is taken per redirect.

Parameters:
- EXC_VECTOR, 32'h0000_0020, common exception entry address.
- HOLD_CYCLES, 2, cycles after a flush during which new exceptions/interrupts are not accepted (range 1..7).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- mem_valid_i  in  1  MEM stage holds a real (non-bubble) instruction
- mem_exc_flags_i  in  5  raw flags {eret, overflow, trap, syscall, invalid_inst}
- mem_pc_i  in  32  MEM instruction address
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot
- cp0_status_i  in  32  forwarded CP0 Status
- cp0_cause_i  in  32  forwarded CP0 Cause
- cp0_epc_i  in  32  forwarded CP0 EPC
- stallreq_id_i  in  1  ID-stage stall request
- stallreq_ex_i  in  1  EX-stage stall request
- exception_type_o  out  32  final exception type to CP0 (0 = none)
- exc_pc_o  out  32  faulting address to CP0 (= mem_pc_i)
- exc_in_delayslot_o  out  1  delay-slot flag to CP0
- flush_o  out  1  flush all pipeline registers
- new_pc_o  out  32  redirect PC, valid while flush_o=1
- stall_o  out  6  per-stage stall {wb,mem,ex,id,if,pc}
- busy_o  out  1  hold-off active

Interface fixed: one clock; reset is asynchronous and active-low. Ports are named clk and rst, with rst=0 meaning reset.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, hold counter=0.
  - All outputs forced to 0 combinationally while rst=0.
- Interrupt pending condition: (cause[15:8] & status[15:8]) != 0 and status[0]=1 (IE) and status[1]=0 (EXL) and mem_valid_i=1.
- Decision is combinational, in IDLE only, same cycle as the MEM instruction. Priority, highest first:
  1. interrupt → 32'h1
  2. invalid_inst → 32'h9
  3. syscall → 32'h8
  4. trap → 32'hd
  5. overflow → 32'hc
  6. eret → 32'he
- Raw flags are ignored when mem_valid_i=0. Multiple flags resolve to the single highest-priority type.
- exception_type_o is nonzero → same cycle: flush_o=1, stall_o=0.
  - new_pc_o = cp0_epc_i for eret, otherwise EXC_VECTOR.
- exc_pc_o and exc_in_delayslot_o pass MEM values through whenever exception_type_o≠0; otherwise they are 0.
- FSM:
  - IDLE → HOLD on any taken exception (including eret); counter loads HOLD_CYCLES-1.
  - HOLD: exception_type_o=0, flush_o=0, busy_o=1, counter decrements each clk.
  - HOLD → IDLE when counter=0 at a clk edge. HOLD lasts exactly HOLD_CYCLES cycles.
- Stall arbitration, applied when no flush:
  - stallreq_ex_i → 6'b001111 (wins over ID).
  - else stallreq_id_i → 6'b000111.
  - else 6'b000000.
  - Stall requests are honoured in HOLD as well.
- Boundary conditions:
  - Flush wins over any simultaneous stall request.
  - Interrupt arriving during HOLD stays pending (level) and is taken in the first IDLE cycle if still enabled.
  - EXL=1 masks interrupts but not synchronous exceptions.
  - Reset mid-HOLD returns to IDLE immediately.

Optional Feature:
- Macro: EXC_CTRL_STATS_EN
- Defined:
  - Adds output exc_count_o[31:0], reset 0.
  - Increments at each clk edge where flush_o=1 and exception_type_o≠32'he (eret not counted).
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared defines (defines.v): exception type codes (Exc_Interrupt, Exc_Syscall, Exc_InvalidInst, Exc_Trap, Exc_Overflow, Exc_Eret), ExceptionTypeBus, Status/Cause bit indices, stall vector constants, EXC_VECTOR default.
- One natural sub-module: exc_prio_enc, the combinational priority encoder (flags + interrupt pending → type code).
- FSM, stall arbitration and PC mux stay in exc_ctrl.

Test Plan:
- Reset → all outputs 0, busy_o=0. Release reset, drive syscall flag with mem_valid_i=1, mem_pc_i=32'h100 → exception_type_o=32'h8, flush_o=1, new_pc_o=32'h20, exc_pc_o=32'h100. busy_o=1 for next 2 cycles.
- Set status=32'h0000_0401 and cause[10]=1 together with the overflow flag → type 32'h1 (interrupt wins). Repeat with status[1]=1 → type 32'hc.
- Eret flag with cp0_epc_i=32'h0000_1234 → flush_o=1, new_pc_o=32'h1234, type 32'he.
- Syscall flag held high across the flush plus 2 HOLD cycles → exactly one flush pulse. Flag still high at cycle 3 → second flush.
- stallreq_id_i and stallreq_ex_i both high → stall_o=6'b001111. Add a trap flag the same cycle → stall_o=0, flush_o=1.
- Assert rst=0 mid-HOLD → busy_o drops asynchronously. After release, an exception in the first cycle is taken immediately. With EXC_CTRL_STATS_EN, exc_count_o increments 0→1.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared exception codes, CP0 bit indices, stall vectors and FSM state type
package exc_ctrl_pkg;

    typedef logic [31:0] exc_type_t;

    // Final exception type codes presented to CP0
    localparam exc_type_t EXC_NONE         = 32'h0000_0000;
    localparam exc_type_t EXC_INTERRUPT    = 32'h0000_0001;
    localparam exc_type_t EXC_SYSCALL      = 32'h0000_0008;
    localparam exc_type_t EXC_INVALID_INST = 32'h0000_0009;
    localparam exc_type_t EXC_OVERFLOW     = 32'h0000_000c;
    localparam exc_type_t EXC_TRAP         = 32'h0000_000d;
    localparam exc_type_t EXC_ERET         = 32'h0000_000e;

    // Bit positions inside the raw MEM flag vector {eret, overflow, trap, syscall, invalid_inst}
    localparam int FLAG_INVALID_INST = 0;
    localparam int FLAG_SYSCALL      = 1;
    localparam int FLAG_TRAP         = 2;
    localparam int FLAG_OVERFLOW     = 3;
    localparam int FLAG_ERET         = 4;

    // CP0 Status / Cause fields
    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int INT_MASK_LO    = 8;
    localparam int INT_MASK_HI    = 15;

    // Stall vectors {wb, mem, ex, id, if, pc}
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam logic [31:0] EXC_VECTOR_DEFAULT  = 32'h0000_0020;
    localparam int          HOLD_CYCLES_DEFAULT = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } exc_state_t;

    // An interrupt is pending when an enabled line is raised, IE=1, EXL=0 and
    // there is a real instruction in MEM to attach the exception to.
    function automatic logic irq_pending(input logic [31:0] status,
                                         input logic [31:0] cause,
                                         input logic        valid);
        logic w_lines;
        w_lines = |(cause[INT_MASK_HI:INT_MASK_LO] & status[INT_MASK_HI:INT_MASK_LO]);
        return w_lines && status[STATUS_IE_BIT] && !status[STATUS_EXL_BIT] && valid;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - MEM/CP0/stall bundle between the pipeline and the exception controller
interface exc_ctrl_if;
    logic        mem_valid_i;
    logic [4:0]  mem_exc_flags_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic [31:0] exception_type_o;
    logic [31:0] exc_pc_o;
    logic        exc_in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [5:0]  stall_o;
    logic        busy_o;

    // Pipeline side: drives MEM/CP0/stall requests, consumes control outputs
    modport master (
        output mem_valid_i, mem_exc_flags_i, mem_pc_i, mem_in_delayslot_i,
        output cp0_status_i, cp0_cause_i, cp0_epc_i, stallreq_id_i, stallreq_ex_i,
        input  exception_type_o, exc_pc_o, exc_in_delayslot_o, flush_o,
        input  new_pc_o, stall_o, busy_o
    );

    // Controller side
    modport slave (
        input  mem_valid_i, mem_exc_flags_i, mem_pc_i, mem_in_delayslot_i,
        input  cp0_status_i, cp0_cause_i, cp0_epc_i, stallreq_id_i, stallreq_ex_i,
        output exception_type_o, exc_pc_o, exc_in_delayslot_o, flush_o,
        output new_pc_o, stall_o, busy_o
    );
endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// rtl/exc_ctrl_prio_enc.sv - priority encoder from raw flags + pending interrupt to exception type
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic      i_valid,
    input  logic      i_irq_pending,
    input  logic [4:0] i_flags,
    output exc_type_t o_type
);

    // Highest-priority cause wins; bubbles never raise a synchronous exception
    always_comb begin
        o_type = EXC_NONE;
        if (i_irq_pending) begin
            o_type = EXC_INTERRUPT;
        end else if (i_valid) begin
            if (i_flags[FLAG_INVALID_INST])  o_type = EXC_INVALID_INST;
            else if (i_flags[FLAG_SYSCALL])  o_type = EXC_SYSCALL;
            else if (i_flags[FLAG_TRAP])     o_type = EXC_TRAP;
            else if (i_flags[FLAG_OVERFLOW]) o_type = EXC_OVERFLOW;
            else if (i_flags[FLAG_ERET])     o_type = EXC_ERET;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception resolve, flush/redirect, stall arbitration, hold-off FSM (optional EXC_CTRL_STATS_EN)
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
    parameter int          HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    exc_ctrl_if.slave   bus
`ifdef EXC_CTRL_STATS_EN
    ,
    output logic [31:0] exc_count_o
`endif
);

    localparam logic [2:0] HOLD_LOAD = 3'(HOLD_CYCLES - 1);

    exc_state_t r_state;
    exc_state_t w_state_next;
    logic [2:0] r_hold_cnt;
    logic [2:0] w_hold_cnt_next;

    logic       w_irq_pending;
    exc_type_t  w_enc_type;
    exc_type_t  w_type;
    logic       w_flush;
    logic [5:0] w_stall_arb;

    assign w_irq_pending = irq_pending(bus.cp0_status_i, bus.cp0_cause_i, bus.mem_valid_i);

    exc_prio_enc u_prio_enc (
        .i_valid       (bus.mem_valid_i),
        .i_irq_pending (w_irq_pending),
        .i_flags       (bus.mem_exc_flags_i),
        .o_type        (w_enc_type)
    );

    // Exceptions are only accepted in IDLE; reset silences every output
    assign w_type  = (rst && r_state == ST_IDLE) ? w_enc_type : EXC_NONE;
    assign w_flush = (w_type != EXC_NONE);

    // Stall arbitration: EX stall covers ID stall; a flush overrides both
    always_comb begin
        w_stall_arb = STALL_NONE;
        if (bus.stallreq_ex_i)      w_stall_arb = STALL_EX;
        else if (bus.stallreq_id_i) w_stall_arb = STALL_ID;
    end

    assign bus.exception_type_o   = w_type;
    assign bus.flush_o            = w_flush;
    assign bus.exc_pc_o           = w_flush ? bus.mem_pc_i : 32'h0;
    assign bus.exc_in_delayslot_o = w_flush & bus.mem_in_delayslot_i;
    assign bus.new_pc_o           = !w_flush ? 32'h0 :
                                    (w_type == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
    assign bus.stall_o            = (rst && !w_flush) ? w_stall_arb : STALL_NONE;
    assign bus.busy_o             = rst && (r_state == ST_HOLD);

    // State and hold counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    // Next state: a taken exception opens a hold-off window of HOLD_CYCLES cycles
    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_flush) begin
                    w_state_next    = ST_HOLD;
                    w_hold_cnt_next = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == 3'd0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_hold_cnt_next = r_hold_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_hold_cnt_next = 3'd0;
            end
        endcase
    end

`ifdef EXC_CTRL_STATS_EN
    logic [31:0] r_exc_count;

    // Saturating count of taken exceptions, eret excluded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exc_count <= 32'h0;
        end else if (w_flush && w_type != EXC_ERET && r_exc_count != 32'hFFFF_FFFF) begin
            r_exc_count <= r_exc_count + 32'h1;
        end
    end

    assign exc_count_o = r_exc_count;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    exc_ctrl_if ifc ();

`ifdef EXC_CTRL_STATS_EN
    logic [31:0] exc_count;
`endif

    exc_ctrl #(
        .EXC_VECTOR  (32'h0000_0020),
        .HOLD_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
`ifdef EXC_CTRL_STATS_EN
        ,
        .exc_count_o (exc_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [4:0] flags, input logic [31:0] pc,
                         input logic ds, input logic [31:0] status, input logic [31:0] cause,
                         input logic [31:0] epc, input logic sid, input logic sex);
        ifc.mem_valid_i        = valid;
        ifc.mem_exc_flags_i    = flags;
        ifc.mem_pc_i           = pc;
        ifc.mem_in_delayslot_i = ds;
        ifc.cp0_status_i       = status;
        ifc.cp0_cause_i        = cause;
        ifc.cp0_epc_i          = epc;
        ifc.stallreq_id_i      = sid;
        ifc.stallreq_ex_i      = sex;
    endtask

    task automatic step(input logic valid, input logic [4:0] flags, input logic [31:0] pc,
                        input logic ds, input logic [31:0] status, input logic [31:0] cause,
                        input logic [31:0] epc, input logic sid, input logic sex);
        @(negedge clk);
        drive(valid, flags, pc, ds, status, cause, epc, sid, sex);
        #1;
    endtask

    task automatic hold2(input string tag);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 5'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
            chk({tag, "_busy"}, 32'(ifc.busy_o), 32'h1);
            chk({tag, "_flush"}, 32'(ifc.flush_o), 32'h0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(1'b1, 5'b00010, 32'h100, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        #3;
        chk("rst_type",  ifc.exception_type_o, 32'h0);
        chk("rst_flush", 32'(ifc.flush_o), 32'h0);
        chk("rst_stall", 32'(ifc.stall_o), 32'h0);
        chk("rst_busy",  32'(ifc.busy_o), 32'h0);
        chk("rst_newpc", ifc.new_pc_o, 32'h0);
        chk("rst_excpc", ifc.exc_pc_o, 32'h0);
`ifdef EXC_CTRL_STATS_EN
        chk("rst_count", exc_count, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 5'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Syscall with delay slot
        step(1'b1, 5'b00010, 32'h100, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sys_type",  ifc.exception_type_o, 32'h8);
        chk("sys_flush", 32'(ifc.flush_o), 32'h1);
        chk("sys_newpc", ifc.new_pc_o, 32'h20);
        chk("sys_excpc", ifc.exc_pc_o, 32'h100);
        chk("sys_ds",    32'(ifc.exc_in_delayslot_o), 32'h1);
        chk("sys_busy",  32'(ifc.busy_o), 32'h0);
        hold2("sys_hold");
        step(1'b0, 5'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sys_idle_busy", 32'(ifc.busy_o), 32'h0);
`ifdef EXC_CTRL_STATS_EN
        chk("sys_count", exc_count, 32'h1);
`endif

        // Flags ignored on a bubble
        step(1'b0, 5'b11111, 32'h200, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("bubble_type", ifc.exception_type_o, 32'h0);

        // invalid_inst outranks syscall
        step(1'b1, 5'b00011, 32'h204, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("inv_type", ifc.exception_type_o, 32'h9);
        chk("inv_ds",   32'(ifc.exc_in_delayslot_o), 32'h0);
        hold2("inv_hold");

        // Interrupt beats overflow
        step(1'b1, 5'b01000, 32'h300, 1'b0, 32'h0000_0401, 32'h0000_0400, 32'h0, 1'b0, 1'b0);
        chk("irq_type",  ifc.exception_type_o, 32'h1);
        chk("irq_newpc", ifc.new_pc_o, 32'h20);
        hold2("irq_hold");

        // EXL masks the interrupt, overflow taken
        step(1'b1, 5'b01000, 32'h304, 1'b0, 32'h0000_0403, 32'h0000_0400, 32'h0, 1'b0, 1'b0);
        chk("exl_type", ifc.exception_type_o, 32'hc);
        hold2("exl_hold");

        // Eret redirects to EPC
        step(1'b1, 5'b10000, 32'h400, 1'b0, 32'h0, 32'h0, 32'h0000_1234, 1'b0, 1'b0);
        chk("eret_type",  ifc.exception_type_o, 32'he);
        chk("eret_flush", 32'(ifc.flush_o), 32'h1);
        chk("eret_newpc", ifc.new_pc_o, 32'h1234);
        hold2("eret_hold");

        // Syscall held high: one flush, two silent cycles, then a second flush
        step(1'b1, 5'b00010, 32'h500, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("held_flush0", 32'(ifc.flush_o), 32'h1);
        step(1'b1, 5'b00010, 32'h500, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("held_flush1", 32'(ifc.flush_o), 32'h0);
        chk("held_type1",  ifc.exception_type_o, 32'h0);
        step(1'b1, 5'b00010, 32'h500, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("held_flush2", 32'(ifc.flush_o), 32'h0);
        chk("held_busy2",  32'(ifc.busy_o), 32'h1);
        step(1'b1, 5'b00010, 32'h500, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("held_flush3", 32'(ifc.flush_o), 32'h1);
        chk("held_type3",  ifc.exception_type_o, 32'h8);
        hold2("held_hold");

        // Stall arbitration and flush priority
        step(1'b0, 5'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("stall_both",  32'(ifc.stall_o), 32'h0f);
        chk("stall_noflush", 32'(ifc.flush_o), 32'h0);
        step(1'b1, 5'b00100, 32'h600, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("trap_stall", 32'(ifc.stall_o), 32'h0);
        chk("trap_flush", 32'(ifc.flush_o), 32'h1);
        chk("trap_type",  ifc.exception_type_o, 32'hd);
        step(1'b0, 5'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("hold_stall_ex", 32'(ifc.stall_o), 32'h0f);
        chk("hold_stall_busy", 32'(ifc.busy_o), 32'h1);
        step(1'b0, 5'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("hold_stall_id", 32'(ifc.stall_o), 32'h07);
        step(1'b0, 5'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("idle_stall_id", 32'(ifc.stall_o), 32'h07);
        chk("idle_stall_busy", 32'(ifc.busy_o), 32'h0);

        // Interrupt raised during HOLD is taken in the first IDLE cycle
        step(1'b1, 5'b00010, 32'h700, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("pend_sys", ifc.exception_type_o, 32'h8);
        step(1'b1, 5'b0, 32'h704, 1'b0, 32'h0000_0401, 32'h0000_0400, 32'h0, 1'b0, 1'b0);
        chk("pend_hold1", ifc.exception_type_o, 32'h0);
        step(1'b1, 5'b0, 32'h704, 1'b0, 32'h0000_0401, 32'h0000_0400, 32'h0, 1'b0, 1'b0);
        chk("pend_hold2", ifc.exception_type_o, 32'h0);
        step(1'b1, 5'b0, 32'h708, 1'b0, 32'h0000_0401, 32'h0000_0400, 32'h0, 1'b0, 1'b0);
        chk("pend_take",  ifc.exception_type_o, 32'h1);
        chk("pend_excpc", ifc.exc_pc_o, 32'h708);
        hold2("pend_hold");

        // Reset mid-HOLD, then an exception in the first cycle after release
        step(1'b1, 5'b00010, 32'h800, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("mid_sys", 32'(ifc.flush_o), 32'h1);
        step(1'b0, 5'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("mid_busy", 32'(ifc.busy_o), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(ifc.busy_o), 32'h0);
        chk("mid_rst_stall", 32'(ifc.stall_o), 32'h0);
`ifdef EXC_CTRL_STATS_EN
        chk("mid_rst_count", exc_count, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 5'b00010, 32'h900, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("post_rst_type",  ifc.exception_type_o, 32'h8);
        chk("post_rst_flush", 32'(ifc.flush_o), 32'h1);
        chk("post_rst_excpc", ifc.exc_pc_o, 32'h900);
        step(1'b0, 5'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("post_rst_busy", 32'(ifc.busy_o), 32'h1);
`ifdef EXC_CTRL_STATS_EN
        chk("post_rst_count", exc_count, 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
